// File: rtl/mem_resp.sv
// Memory-side responder: word requests served from an internal synchronous RAM
// as a read-then-commit sequence. Define MEM_RESP_RANGE_CHK_EN to enable the address range check.
module mem_resp #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        err
);

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rw_q;
  logic                  oor;
  logic                  req_oor;
  logic                  wr_en;
  logic [31:0]           ram_q;
  logic [31:0]           mem [DEPTH];

`ifdef MEM_RESP_RANGE_CHK_EN
  logic err_q;
  assign req_oor = (addr >> DEPTH_LOG2) != '0;
  assign err     = err_q;
`else
  logic unused_hi;
  assign unused_hi = |addr[29:DEPTH_LOG2];
  assign req_oor   = 1'b0;
  assign err       = 1'b0;
`endif

  // Commit is keyed off the registered state, so an async reset during RESP
  // drops the FSM to IDLE before the edge and suppresses the write.
  assign wr_en = (state == RESP) && (rw_q == WRITE) && !oor;

  always_ff @(posedge clk) begin
    if (state == IDLE && as_ == ENABLE_)
      ram_q <= mem[addr[DEPTH_LOG2-1:0]];
    if (wr_en)
      mem[idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      rw_q    <= READ;
      oor     <= 1'b0;
      rd_data <= '0;
      rdy_    <= DISABLE_;
`ifdef MEM_RESP_RANGE_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rdy_ <= DISABLE_;
          if (as_ == ENABLE_) begin
            idx   <= addr[DEPTH_LOG2-1:0];
            rw_q  <= rw;
            oor   <= req_oor;
            state <= FETCH;
          end
        end
        FETCH: begin
          rd_data <= oor ? '0 : ram_q;
          rdy_    <= ENABLE_;
`ifdef MEM_RESP_RANGE_CHK_EN
          err_q   <= oor;
`endif
          state   <= RESP;
        end
        RESP: begin
          rdy_  <= DISABLE_;
`ifdef MEM_RESP_RANGE_CHK_EN
          err_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed test-plan steps plus randomized
// requests checked against a word-map reference model.
module tb_mem_resp;

  localparam int unsigned DL    = 12;
  localparam int unsigned DEPTH = 1 << DL;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [int unsigned];

  mem_resp #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request: checks rdy_ timing, err, and the returned (old) word.
  task automatic req(input logic w, input logic [29:0] a, input logic [31:0] d, input bit rmw);
    int unsigned i;
    bit          oor;
    bit          known;
    logic [31:0] exp_old;
    i = int'(a[DL-1:0]);
`ifdef MEM_RESP_RANGE_CHK_EN
    oor = (a[29:DL] != '0);
`else
    oor = 1'b0;
`endif
    known   = oor || model.exists(i);
    exp_old = oor ? 32'h0 : (model.exists(i) ? model[i] : 32'h0);
    @(negedge clk);
    as_ = 1'b0; rw = w; addr = a; wr_data = d;
    @(negedge clk);
    chk("rdy_fetch", {31'b0, rdy_}, 32'd1);
    @(negedge clk);
    chk("rdy_resp", {31'b0, rdy_}, 32'd0);
    chk("err_resp", {31'b0, err}, {31'b0, oor});
    if (known) chk("rd_data", rd_data, exp_old);
    if (rmw) wr_data = {rd_data[31:8], 8'hAA};
    as_ = 1'b1;
    if (w == WRITE && !oor) model[i] = rmw ? {exp_old[31:8], 8'hAA} : d;
    @(negedge clk);
    chk("rdy_after", {31'b0, rdy_}, 32'd1);
    chk("err_after", {31'b0, err}, 32'd0);
  endtask

  initial begin
    logic [29:0] ra;
    reset = 1'b1; as_ = 1'b1; rw = READ; addr = '0; wr_data = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_rdy", {31'b0, rdy_}, 32'd1);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_err", {31'b0, err}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_no_rdy", {31'b0, rdy_}, 32'd1);
    end

    // Preload a small working set
    for (int k = 0; k < 16; k++) req(WRITE, 30'(k), $urandom, 1'b0);

    // Write then read
    req(WRITE, 30'd5, 32'hDEADBEEF, 1'b0);
    req(READ,  30'd5, 32'h0, 1'b0);
    chk("wr_rd_5", rd_data, 32'hDEADBEEF);

    // Read-modify-write
    req(WRITE, 30'd7, 32'h11223344, 1'b0);
    req(WRITE, 30'd7, 32'h0, 1'b1);
    req(READ,  30'd7, 32'h0, 1'b0);
    chk("rmw_7", rd_data, 32'h112233AA);

    // Back-to-back reads with as_ held low
    req(WRITE, 30'd1, 32'hA1, 1'b0);
    req(WRITE, 30'd2, 32'hB2, 1'b0);
    @(negedge clk);
    as_ = 1'b0; rw = READ; addr = 30'd1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk("b2b_rdy", {31'b0, rdy_}, (j == 2 || j == 5) ? 32'd0 : 32'd1);
      if (j == 2) begin
        chk("b2b_data1", rd_data, 32'hA1);
        addr = 30'd2;
      end
      if (j == 5) begin
        chk("b2b_data2", rd_data, 32'hB2);
        as_ = 1'b1;
      end
    end

    // Reset pulsed during FETCH of a write
    req(WRITE, 30'd3, 32'h0, 1'b0);
    @(negedge clk);
    as_ = 1'b0; rw = WRITE; addr = 30'd3; wr_data = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b1; as_ = 1'b1;
    #2 reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rst_mid_no_rdy", {31'b0, rdy_}, 32'd1);
    end
    chk("rst_mid_rd_data", rd_data, 32'h0);
    req(READ, 30'd3, 32'h0, 1'b0);
    chk("rst_mid_word3", rd_data, 32'h0);

    // Range check / aliasing onto word 0
    req(WRITE, 30'd0, 32'hCAFEF00D, 1'b0);
    req(WRITE, 30'(1 << DL), 32'h12345678, 1'b0);
    req(READ,  30'd0, 32'h0, 1'b0);
`ifdef MEM_RESP_RANGE_CHK_EN
    chk("range_word0", rd_data, 32'hCAFEF00D);
`else
    chk("alias_word0", rd_data, 32'h12345678);
`endif

    // Randomized requests against the model
    for (int k = 0; k < 40; k++) begin
      ra = 30'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra[29:DL] = 18'($urandom);
      req(($urandom_range(0, 1) == 0) ? WRITE : READ, ra, $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
